// File: rtl/detector_scheduler_pkg.sv
// Shared defaults, reset constants and index-width helper for the
// time-shared sliding-window detector.
package detector_scheduler_pkg;

  localparam int PAT_W_DEF = 8;
  localparam logic [PAT_W_DEF-1:0] DEF_PATTERN_DEF = 8'b1100_1001;

  localparam logic RST_DEC      = 1'b0;
  localparam logic RST_MASK_BIT = 1'b1;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/detector_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr
// wins, wrapping around; en=0 suppresses every grant.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic          gnt_vld,
  output logic [IW-1:0] gnt_idx
);

  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    // Upper segment [ptr, N-1] first, then wrap to [0, ptr-1].
    for (int i = 0; i < N; i++) begin
      if (en && !gnt_vld && req[i] && (IW'(i) >= ptr)) begin
        gnt[i]  = 1'b1;
        gnt_vld = 1'b1;
        gnt_idx = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (en && !gnt_vld && req[i] && (IW'(i) < ptr)) begin
        gnt[i]  = 1'b1;
        gnt_vld = 1'b1;
        gnt_idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/detector_scheduler.sv
// One programmable masked pattern matcher shared round-robin among NUM_CH
// serial bit channels, each with its own single-bit holding slot and window.
module detector_scheduler
  import detector_scheduler_pkg::*;
#(
  parameter int                NUM_CH      = 4,
  parameter int                PAT_W       = PAT_W_DEF,
  parameter logic [PAT_W-1:0]  DEF_PATTERN = DEF_PATTERN_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         in_valid,
  input  logic [NUM_CH-1:0]         in_bit,
  output logic [NUM_CH-1:0]         in_ready,
  input  logic                      cfg_we,
  input  logic [PAT_W-1:0]          cfg_pattern,
  input  logic [PAT_W-1:0]          cfg_mask,
  output logic                      dec,
  output logic [$clog2(NUM_CH)-1:0] dec_ch
);

  localparam int IW = ch_idx_w(NUM_CH);
  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FILL_MAX  = FW'(PAT_W);
  localparam logic [FW-1:0] FILL_GATE = FW'(PAT_W - 1);

  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] hold_q, hold_d;
  logic [PAT_W-1:0]  win_q  [NUM_CH];
  logic [PAT_W-1:0]  win_d  [NUM_CH];
  logic [FW-1:0]     fill_q [NUM_CH];
  logic [FW-1:0]     fill_d [NUM_CH];
  logic [IW-1:0]     rr_q, rr_d;
  logic [PAT_W-1:0]  pattern_q, pattern_d;
  logic [PAT_W-1:0]  mask_q, mask_d;
  logic              dec_q, dec_d;
  logic [IW-1:0]     dec_ch_q, dec_ch_d;

  logic [NUM_CH-1:0] gnt;
  logic [NUM_CH-1:0] accept;
  logic              gnt_vld;
  logic [IW-1:0]     gnt_idx;
  logic [PAT_W-1:0]  new_win;
  logic [FW-1:0]     gnt_fill;
  logic              match;

  // A configuration write steals the scheduling slot for its cycle.
  rr_arbiter #(
    .N  (NUM_CH),
    .IW (IW)
  ) u_arb (
    .req     (pend_q),
    .ptr     (rr_q),
    .en      (!cfg_we),
    .gnt     (gnt),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  assign in_ready = ~pend_q | gnt;
  assign accept   = in_valid & in_ready;

  always_comb begin
    new_win  = '0;
    gnt_fill = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) begin
        new_win  = {win_q[i][PAT_W-2:0], hold_q[i]};
        gnt_fill = fill_q[i];
      end
    end
    // Fill is checked before increment so the first full window can match.
    match = gnt_vld && (((new_win ^ pattern_q) & mask_q) == '0) &&
            (gnt_fill >= FILL_GATE);
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      pend_d[i] = accept[i] | (pend_q[i] & ~gnt[i]);
      hold_d[i] = accept[i] ? in_bit[i] : hold_q[i];
      win_d[i]  = win_q[i];
      fill_d[i] = fill_q[i];
      if (cfg_we) begin
        win_d[i]  = '0;
        fill_d[i] = '0;
      end else if (gnt[i]) begin
        win_d[i]  = new_win;
        fill_d[i] = (fill_q[i] == FILL_MAX) ? fill_q[i] : fill_q[i] + 1'b1;
      end
    end
    rr_d = rr_q;
    if (gnt_vld) begin
      rr_d = (gnt_idx == IW'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
    end
    pattern_d = cfg_we ? cfg_pattern : pattern_q;
    mask_d    = cfg_we ? cfg_mask    : mask_q;
    dec_d     = match;
    dec_ch_d  = gnt_vld ? gnt_idx : dec_ch_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q    <= '0;
      hold_q    <= '0;
      rr_q      <= '0;
      pattern_q <= DEF_PATTERN;
      mask_q    <= {PAT_W{RST_MASK_BIT}};
      dec_q     <= RST_DEC;
      dec_ch_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        win_q[i]  <= '0;
        fill_q[i] <= '0;
      end
    end else begin
      pend_q    <= pend_d;
      hold_q    <= hold_d;
      rr_q      <= rr_d;
      pattern_q <= pattern_d;
      mask_q    <= mask_d;
      dec_q     <= dec_d;
      dec_ch_q  <= dec_ch_d;
      for (int i = 0; i < NUM_CH; i++) begin
        win_q[i]  <= win_d[i];
        fill_q[i] <= fill_d[i];
      end
    end
  end

  assign dec    = dec_q;
  assign dec_ch = dec_ch_q;

endmodule

// File: tb/tb_detector_scheduler.sv
// Bench for detector_scheduler: hand vectors, directed corner sequences and
// random traffic checked against a bit-history reference model.
module tb_detector_scheduler;

  localparam int NUM_CH = 4;
  localparam int PAT_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] in_valid, in_bit, in_ready;
  logic              cfg_we;
  logic [PAT_W-1:0]  cfg_pattern, cfg_mask;
  logic              dec;
  logic [1:0]        dec_ch;

  detector_scheduler #(.NUM_CH(NUM_CH), .PAT_W(PAT_W), .DEF_PATTERN(8'b1100_1001)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .in_ready    (in_ready),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_mask    (cfg_mask),
    .dec         (dec),
    .dec_ch      (dec_ch)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending slot per channel plus the history of bits
  // processed since the last clear (oldest first, at most PAT_W kept).
  bit         m_pend [NUM_CH];
  bit         m_hold [NUM_CH];
  bit         m_hist [NUM_CH][$];
  int         m_rr;
  logic [7:0] m_pat, m_mask;
  bit         m_dec;
  int         m_dec_ch;

  int          step_no = 0;
  int          dec_steps[$];
  int          dec_chs[$];
  logic [3:0]  last_ready;

  typedef struct {
    logic [3:0] vld;
    logic [3:0] bits;
    logic [3:0] exp_ready;
    logic       exp_dec;
    logic [1:0] exp_ch;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at step %0d: got %0h, expected %0h", name, step_no, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_pend[i] = 0;
      m_hold[i] = 0;
      m_hist[i].delete();
    end
    m_rr     = 0;
    m_pat    = 8'hC9;
    m_mask   = 8'hFF;
    m_dec    = 0;
    m_dec_ch = 0;
  endfunction

  function automatic int model_grant();
    if (cfg_we) return -1;
    for (int off = 0; off < NUM_CH; off++) begin
      int c = (m_rr + off) % NUM_CH;
      if (m_pend[c]) return c;
    end
    return -1;
  endfunction

  function automatic bit model_match(input int g);
    if (m_hist[g].size() < PAT_W) return 0;
    for (int k = 0; k < PAT_W; k++) begin
      int bp = PAT_W - 1 - k;
      if (m_mask[bp] && (m_hist[g][k] != m_pat[bp])) return 0;
    end
    return 1;
  endfunction

  // One clock: check ready before the edge, advance the model at the edge,
  // check dec on the following falling edge.
  task automatic step();
    int         g;
    logic [3:0] rdy;
    #1;
    g = model_grant();
    for (int i = 0; i < NUM_CH; i++) rdy[i] = !m_pend[i] || (g == i);
    last_ready = in_ready;
    check("in_ready", in_ready, rdy);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_dec = 0;
      if (g >= 0) begin
        m_hist[g].push_back(m_hold[g]);
        if (m_hist[g].size() > PAT_W) void'(m_hist[g].pop_front());
        if (model_match(g)) begin
          m_dec    = 1;
          m_dec_ch = g;
        end
        m_pend[g] = 0;
        m_rr      = (g + 1) % NUM_CH;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (in_valid[i] && rdy[i]) begin
          m_pend[i] = 1;
          m_hold[i] = in_bit[i];
        end
      end
      if (cfg_we) begin
        m_pat  = cfg_pattern;
        m_mask = cfg_mask;
        for (int i = 0; i < NUM_CH; i++) m_hist[i].delete();
      end
    end
    @(negedge clk);
    step_no++;
    check("dec", dec, m_dec);
    if (m_dec) check("dec_ch", dec_ch, m_dec_ch);
    if (dec === 1'b1) begin
      dec_steps.push_back(step_no);
      dec_chs.push_back(dec_ch);
    end
  endtask

  task automatic idle(input int n);
    in_valid = '0;
    in_bit   = '0;
    cfg_we   = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic send_seq(input int ch, input logic [15:0] bits, input int n);
    for (int k = 0; k < n; k++) begin
      in_valid     = '0;
      in_bit       = '0;
      in_valid[ch] = 1'b1;
      in_bit[ch]   = bits[n-1-k];
      step();
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = '0;
    cfg_we   = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic do_cfg(input logic [7:0] pat, input logic [7:0] msk);
    in_valid    = '0;
    cfg_we      = 1'b1;
    cfg_pattern = pat;
    cfg_mask    = msk;
    step();
    cfg_we = 1'b0;
  endtask

  initial begin
    int base, nd;
    int sent[NUM_CH];
    logic [7:0] def_pat;

    def_pat = 8'b1100_1001;
    for (int r = 0; r < 10; r++) begin
      vecs[r].vld       = (r < 8) ? 4'b0001 : 4'b0000;
      vecs[r].bits      = (r < 8) ? {3'b000, def_pat[7-r]} : 4'b0000;
      vecs[r].exp_ready = 4'hF;
      vecs[r].exp_dec   = (r == 8);
      vecs[r].exp_ch    = 2'd0;
    end

    rst = 1'b1; in_valid = '0; in_bit = '0; cfg_we = 1'b0;
    cfg_pattern = '0; cfg_mask = '0;
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 4'hF);
    check("rst_dec", dec, 1'b0);
    check("rst_dec_ch", dec_ch, 2'd0);

    // Default pattern on ch0, driven from the vector table.
    for (int r = 0; r < 10; r++) begin
      in_valid = vecs[r].vld;
      in_bit   = vecs[r].bits;
      step();
      check("tbl_ready", last_ready, vecs[r].exp_ready);
      check("tbl_dec", dec, vecs[r].exp_dec);
      if (vecs[r].exp_dec) check("tbl_dec_ch", dec_ch, vecs[r].exp_ch);
    end

    // Masked pattern with overlapping detections on ch1.
    do_cfg(8'h09, 8'h0F);
    base = step_no; nd = dec_steps.size();
    send_seq(1, 16'b000_0000_1001_001, 11);
    idle(3);
    check("mask_dec_count", dec_steps.size() - nd, 2);
    if (dec_steps.size() - nd == 2) begin
      check("mask_dec1_step", dec_steps[nd] - base, 9);
      check("mask_dec2_step", dec_steps[nd+1] - base, 12);
      check("mask_dec_ch", dec_chs[nd], 1);
    end

    // Fill gate on ch2.
    do_reset();
    do_cfg(8'h09, 8'h0F);
    nd = dec_steps.size();
    send_seq(2, 16'h9, 4);
    idle(3);
    check("fill_gate_no_dec", dec_steps.size() - nd, 0);
    base = step_no; nd = dec_steps.size();
    send_seq(2, 16'h9, 4);
    idle(3);
    check("fill_gate_dec_count", dec_steps.size() - nd, 1);
    if (dec_steps.size() - nd == 1) begin
      check("fill_gate_dec_step", dec_steps[nd] - base, 5);
      check("fill_gate_dec_ch", dec_chs[nd], 2);
    end

    // Contention: six pattern bits per channel, then all four compete.
    do_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      send_seq(c, 16'b11_0010, 6);
      idle(2);
    end
    nd = dec_steps.size();
    for (int c = 0; c < NUM_CH; c++) sent[c] = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      bit done = 1;
      for (int c = 0; c < NUM_CH; c++) begin
        in_valid[c] = (sent[c] < 2);
        in_bit[c]   = (sent[c] != 0);
        if (sent[c] < 2) done = 0;
      end
      if (done) break;
      step();
      for (int c = 0; c < NUM_CH; c++)
        if (in_valid[c] && last_ready[c]) sent[c]++;
    end
    idle(6);
    for (int c = 0; c < NUM_CH; c++) check("cont_bits_accepted", sent[c], 2);
    check("cont_dec_count", dec_steps.size() - nd, 4);
    if (dec_steps.size() - nd == 4)
      for (int c = 0; c < NUM_CH; c++) check("cont_dec_order", dec_chs[nd+c], c);

    // Reset in the middle of a window on ch3.
    do_reset();
    nd = dec_steps.size();
    send_seq(3, 16'b110_0100, 7);
    do_reset();
    check("midrst_in_ready", in_ready, 4'hF);
    send_seq(3, 16'h1, 1);
    idle(3);
    check("midrst_no_dec", dec_steps.size() - nd, 0);

    // Configuration write in the middle of a window on ch0.
    do_reset();
    nd = dec_steps.size();
    send_seq(0, 16'b110_0100, 7);
    do_cfg(8'hC9, 8'hFF);
    check("midcfg_pend_kept", last_ready[0], 1'b0);
    send_seq(0, 16'h1, 1);
    idle(3);
    check("midcfg_no_dec", dec_steps.size() - nd, 0);

    // Random traffic against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      rst         = ($urandom_range(0, 499) == 0);
      cfg_we      = !rst && ($urandom_range(0, 39) == 0);
      cfg_pattern = 8'($urandom);
      cfg_mask    = 8'($urandom) & 8'($urandom) & 8'($urandom);
      in_valid    = 4'($urandom);
      in_bit      = 4'($urandom);
      step();
    end
    rst = 1'b0;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
